// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready handshakes and iterative RV32M mul/div.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational multiplier instead.
module alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALUControl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Carry,
  output logic            OverFlow,
  output logic            Zero,
  output logic            Negative
);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND   = 4'h2, OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_SLT  = 4'h5, OP_SLTU  = 4'h6, OP_PASB = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8, OP_MULH = 4'h9, OP_MULHU = 4'hA, OP_DIV  = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC, OP_REM  = 4'hD, OP_REMU  = 4'hE;

`ifdef ALU_SEQ_FAST_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

  typedef struct packed {
    logic [3:0] op;
    logic       neg_ab;  // operand signs differ (MULH product / quotient)
    logic       neg_a;   // dividend negative (remainder)
  } ctx_t;

  state_t            state, nxt;
  ctx_t              ctx;
  logic [XLEN-1:0]   hi, lo, m;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   bx, sc_res, fin, nhi, nlo;
  logic [XLEN:0]     sum_c, sh, diff;
  logic              sc_c, sc_v, sgn, a_neg, b_neg, div_ovf, go_div;
  logic              accept, iter, last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign Zero      = (Result == '0);
  assign Negative  = Result[XLEN-1];
  assign accept    = in_ready && in_valid && !flush;
  assign last      = (cnt == CNT_W'(XLEN - 1));

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*XLEN-1:0] uprod;
  logic [XLEN-1:0]   mulh_s;
  // Signed high half recovered from the unsigned product by subtracting the sign corrections.
  always_comb begin
    uprod  = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};
    mulh_s = uprod[2*XLEN-1:XLEN] - (A[XLEN-1] ? B : '0) - (B[XLEN-1] ? A : '0);
  end
  assign iter = (state == S_DIV);
`else
  logic go_mul;
  logic [XLEN:0] msum;
  assign iter = (state == S_DIV) || (state == S_MUL);
`endif

  always_comb begin : decode
    bx      = (ALUControl == OP_SUB) ? ~B : B;
    sum_c   = {1'b0, A} + {1'b0, bx} + {{XLEN{1'b0}}, ALUControl == OP_SUB};
    sgn     = ALUControl inside {OP_MULH, OP_DIV, OP_REM};
    a_neg   = sgn & A[XLEN-1];
    b_neg   = sgn & B[XLEN-1];
    div_ovf = (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    go_div  = 1'b0;
`ifndef ALU_SEQ_FAST_MUL_EN
    go_mul  = 1'b0;
`endif
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        sc_res = sum_c[XLEN-1:0];
        sc_c   = sum_c[XLEN];
        sc_v   = (A[XLEN-1] == bx[XLEN-1]) && (sum_c[XLEN-1] != A[XLEN-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, A < B};
      OP_PASB: sc_res = B;
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL:   sc_res = uprod[XLEN-1:0];
      OP_MULH:  sc_res = mulh_s;
      OP_MULHU: sc_res = uprod[2*XLEN-1:XLEN];
`else
      OP_MUL, OP_MULH, OP_MULHU: go_mul = 1'b1;
`endif
      OP_DIV, OP_REM: begin
        if (B == '0)      sc_res = (ALUControl == OP_DIV) ? '1 : A;
        else if (div_ovf) sc_res = (ALUControl == OP_DIV) ? A : '0;
        else              go_div = 1'b1;
      end
      OP_DIVU, OP_REMU: begin
        if (B == '0) sc_res = (ALUControl == OP_DIVU) ? '1 : A;
        else         go_div = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  // One iteration step; the last step is sign-fixed straight into Result.
  always_comb begin : step
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, m};
    nhi  = hi;
    nlo  = lo;
`ifndef ALU_SEQ_FAST_MUL_EN
    msum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
`endif
    if (state == S_DIV) begin
      if (diff[XLEN]) begin
        nhi = sh[XLEN-1:0];
        nlo = {lo[XLEN-2:0], 1'b0};
      end else begin
        nhi = diff[XLEN-1:0];
        nlo = {lo[XLEN-2:0], 1'b1};
      end
    end
`ifndef ALU_SEQ_FAST_MUL_EN
    else begin
      nhi = msum[XLEN:1];
      nlo = {msum[0], lo[XLEN-1:1]};
    end
`endif
    fin = '0;
    case (ctx.op)
`ifndef ALU_SEQ_FAST_MUL_EN
      OP_MUL:   fin = nlo;
      OP_MULH:  fin = ctx.neg_ab ? (~nhi + {{(XLEN-1){1'b0}}, nlo == '0}) : nhi;
      OP_MULHU: fin = nhi;
`endif
      OP_DIV:   fin = ctx.neg_ab ? -nlo : nlo;
      OP_DIVU:  fin = nlo;
      OP_REM:   fin = ctx.neg_a ? -nhi : nhi;
      OP_REMU:  fin = nhi;
      default:  fin = nlo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin : fsm
    nxt = state;
    case (state)
      S_IDLE: if (in_valid) begin
        if (go_div) nxt = S_DIV;
`ifndef ALU_SEQ_FAST_MUL_EN
        else if (go_mul) nxt = S_MUL;
`endif
        else nxt = S_DONE;
      end
`ifndef ALU_SEQ_FAST_MUL_EN
      S_MUL:  if (last) nxt = S_DONE;
`endif
      S_DIV:  if (last) nxt = S_DONE;
      S_DONE: if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result   <= '0;
      Carry    <= 1'b0;
      OverFlow <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      cnt      <= '0;
      ctx      <= '0;
    end else if (accept) begin
      Result   <= sc_res;
      Carry    <= sc_c;
      OverFlow <= sc_v;
      hi       <= '0;
      lo       <= a_neg ? -A : A;
      m        <= b_neg ? -B : B;
      cnt      <= '0;
      ctx      <= '{op: ALUControl, neg_ab: a_neg ^ b_neg, neg_a: a_neg};
    end else if (iter && !flush) begin
      hi  <= nhi;
      lo  <= nlo;
      cnt <= cnt + CNT_W'(1);
      if (last) Result <= fin;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan steps plus randomized ops
// against an arithmetic reference model (64-bit products, native signed division).
module tb_alu_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  ALUControl = '0;
  logic        in_ready, out_valid, Carry, OverFlow, Zero, Negative;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Carry(Carry), .OverFlow(OverFlow), .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [3:0] RST_OP = 4'hC;
`else
  localparam int MUL_LAT = XLEN + 1;
  localparam logic [3:0] RST_OP = 4'hA;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] p, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
    u  = {32'b0, a} * {32'b0, b};
    q  = 0;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return (sa < sb) ? 32'd1 : 32'd0;
      4'h6: return (a < b) ? 32'd1 : 32'd0;
      4'h7: return b;
      4'h8: return p[31:0];
      4'h9: return p[63:32];
      4'hA: return u[63:32];
      4'hB: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return 32'(q); end
      4'hC: return (b == 0) ? 32'hFFFFFFFF : a / b;
      4'hD: begin if (b == 0) return a; q = sa % sb; return 32'(q); end
      4'hE: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'h0) return (64'(a) + 64'(b)) > 64'hFFFFFFFF;
    if (op == 4'h1) return a >= b;
    return 1'b0;
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 4'h0)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'h1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h8, 4'h9, 4'hA: return MUL_LAT;
      4'hB, 4'hD: return (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : XLEN + 1;
      4'hC, 4'hE: return (b == 0) ? 1 : XLEN + 1;
      default: return 1;
    endcase
  endfunction

  // Called at posedge+1 with the block idle; holds out_ready low for bp cycles after DONE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [31:0] er;
    int lat;
    string t;
    er = ref_res(op, a, b);
    t  = $sformatf("op%0h a=%h b=%h", op, a, b);
    check({t, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; A = a; B = b; ALUControl = op;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({t, " out_valid"}, 32'(out_valid), 32'd1);
    check({t, " latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
    check({t, " Result"}, Result, er);
    check({t, " Carry"}, 32'(Carry), 32'(ref_carry(op, a, b)));
    check({t, " OverFlow"}, 32'(OverFlow), 32'(ref_ovf(op, a, b)));
    check({t, " Zero"}, 32'(Zero), 32'(er == 0));
    check({t, " Negative"}, 32'(Negative), 32'(er[31]));
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({t, " hold Result"}, Result, er);
      check({t, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({t, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check({t, " release out_valid"}, 32'(out_valid), 32'd0);
    check({t, " release in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          seen;

    // Reset state
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset Result", Result, 32'd0);
    check("reset Zero", 32'(Zero), 32'd1);
    check("reset Carry", 32'(Carry), 32'd0);
    check("reset OverFlow", 32'(OverFlow), 32'd0);
    check("reset Negative", 32'(Negative), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed test-plan operations
    do_op(4'h0, 32'hFFFFFFFF, 32'h00000001, 0);
    do_op(4'h1, 32'h80000000, 32'h00000001, 0);
    do_op(4'h6, 32'h00000001, 32'hFFFFFFFF, 0);
    do_op(4'h9, 32'hFFFFFFFE, 32'h00000003, 0);
    do_op(4'hA, 32'hFFFFFFFE, 32'h00000003, 0);
    do_op(4'hB, 32'hFFFFFFF9, 32'h00000002, 0);
    do_op(4'hD, 32'hFFFFFFF9, 32'h00000002, 0);
    do_op(4'hC, 32'h00000007, 32'h00000000, 0);
    do_op(4'hB, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(4'hD, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(4'hF, 32'h12345678, 32'h9ABCDEF0, 0);
    do_op(4'h8, 32'h80000000, 32'h80000000, 0);
    // Backpressure: 5 cycles with junk in_valid held high
    do_op(4'h4, 32'hA5A5A5A5, 32'h0F0F0F0F, 5);
    do_op(4'hE, 32'h00000064, 32'h00000007, 5);

    // Flush on the 10th cycle of a DIVU
    in_valid = 1'b1; A = 32'd100; B = 32'd7; ALUControl = 4'hC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (9) begin @(posedge clk); #1; if (out_valid) seen++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    repeat (XLEN + 4) begin if (out_valid) seen++; @(posedge clk); #1; end
    check("flush no out_valid", 32'(seen), 32'd0);
    do_op(4'hC, 32'd100, 32'd7, 0);

    // Flush in the same cycle as in_valid blocks the accept
    in_valid = 1'b1; flush = 1'b1; A = 32'd1; B = 32'd2; ALUControl = 4'h0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("flush+valid out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-operation
    in_valid = 1'b1; A = 32'hFFFFFFFE; B = 32'd3; ALUControl = RST_OP;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid) seen++; end
    #2 rst = 1'b1;
    #1;
    check("rst mid-op in_ready", 32'(in_ready), 32'd1);
    check("rst mid-op out_valid", 32'(out_valid), 32'd0);
    check("rst mid-op Result", Result, 32'd0);
    check("rst mid-op early out_valid", 32'(seen), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'hA, 32'hFFFFFFFE, 32'd3, 0);

    // Randomized ops, biased toward divide corner cases
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = ra;
        default: ;
      endcase
      do_op(op, ra, rb, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
